// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline register with a skid slot: registered in_ready, one-cycle latency,
// flush/interrupt clear with optional PC retention.
module pipe_stage_buf #(
   parameter int IR_W    = 32,
   parameter int PC_W    = 32,
   parameter int PAY_W   = 96,
   parameter int EXC_W   = 5,
   parameter bit KEEP_PC = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             int_clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IR_W-1:0]  in_ir,
   input  logic [PC_W-1:0]  in_pc8,
   input  logic [PAY_W-1:0] in_pay,
   input  logic [EXC_W-1:0] in_exc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IR_W-1:0]  out_ir,
   output logic [PC_W-1:0]  out_pc8,
   output logic [PAY_W-1:0] out_pay,
   output logic [EXC_W-1:0] out_exc,
   output logic [1:0]       occ
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_state_t;

   typedef struct packed {
      logic [IR_W-1:0]  ir;
      logic [PC_W-1:0]  pc8;
      logic [PAY_W-1:0] pay;
      logic [EXC_W-1:0] exc;
   } entry_t;

   occ_state_t state, state_nxt;
   entry_t     head_q, head_d;
   entry_t     skid_q, skid_d;
   entry_t     in_ent;
   logic       push, pop, flush;

   // State encoding doubles as the entry count, so occ needs no extra logic.
   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign occ       = state;

   assign push  = in_valid & in_ready;
   assign pop   = out_valid & out_ready;
   assign flush = clr | int_clr;

   assign in_ent = '{ir: in_ir, pc8: in_pc8, pay: in_pay, exc: in_exc};

   assign out_ir  = head_q.ir;
   assign out_pc8 = head_q.pc8;
   assign out_pay = head_q.pay;
   assign out_exc = head_q.exc;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= EMPTY;
         head_q <= '0;
         skid_q <= '0;
      end else begin
         state  <= state_nxt;
         head_q <= head_d;
         skid_q <= skid_d;
      end
   end

   // Head fields are zeroed whenever the head empties so outputs read 0 while invalid;
   // the PC field is left alone on a plain drain and only touched by flush policy.
   always_comb begin
      state_nxt = state;
      head_d    = head_q;
      skid_d    = skid_q;
      if (flush) begin
         state_nxt  = EMPTY;
         head_d     = '0;
         head_d.pc8 = KEEP_PC ? head_q.pc8 : '0;
         skid_d     = '0;
      end else begin
         unique case (state)
            EMPTY: begin
               if (push) begin
                  head_d    = in_ent;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (push && pop) begin
                  head_d = in_ent;
               end else if (push) begin
                  skid_d    = in_ent;
                  state_nxt = FULL;
               end else if (pop) begin
                  head_d     = '0;
                  head_d.pc8 = head_q.pc8;
                  state_nxt  = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  head_d    = skid_q;
                  skid_d    = '0;
                  state_nxt = ONE;
               end
            end
            default: begin
               state_nxt = EMPTY;
               head_d    = '0;
               skid_d    = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a default-width KEEP_PC=1 instance and a narrow KEEP_PC=0
// instance share stimulus and are both checked against one queue-based model.
module tb_pipe_stage_buf;

   logic clk = 1'b0;
   logic reset, clr, int_clr, in_valid, out_ready;
   logic [31:0] in_ir, in_pc8;
   logic [95:0] in_pay;
   logic [4:0]  in_exc;

   logic        in_ready_a, out_valid_a;
   logic [31:0] out_ir_a, out_pc8_a;
   logic [95:0] out_pay_a;
   logic [4:0]  out_exc_a;
   logic [1:0]  occ_a;

   logic        in_ready_b, out_valid_b;
   logic [15:0] out_ir_b;
   logic [31:0] out_pc8_b;
   logic [7:0]  out_pay_b;
   logic [2:0]  out_exc_b;
   logic [1:0]  occ_b;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   typedef struct packed {
      logic [31:0] ir;
      logic [31:0] pc;
      logic [95:0] pay;
      logic [4:0]  exc;
   } ent_t;

   ent_t        q[$];
   logic [31:0] pc_a, pc_b;
   bit          pc_a_known = 1'b0;
   bit          pc_b_known = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_buf #(.KEEP_PC(1'b1)) dut_a (
      .clk(clk), .reset(reset), .clr(clr), .int_clr(int_clr),
      .in_valid(in_valid), .in_ready(in_ready_a),
      .in_ir(in_ir), .in_pc8(in_pc8), .in_pay(in_pay), .in_exc(in_exc),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .out_ir(out_ir_a), .out_pc8(out_pc8_a), .out_pay(out_pay_a), .out_exc(out_exc_a),
      .occ(occ_a)
   );

   pipe_stage_buf #(.IR_W(16), .PAY_W(8), .EXC_W(3), .KEEP_PC(1'b0)) dut_b (
      .clk(clk), .reset(reset), .clr(clr), .int_clr(int_clr),
      .in_valid(in_valid), .in_ready(in_ready_b),
      .in_ir(in_ir[15:0]), .in_pc8(in_pc8), .in_pay(in_pay[7:0]), .in_exc(in_exc[2:0]),
      .out_valid(out_valid_b), .out_ready(out_ready),
      .out_ir(out_ir_b), .out_pc8(out_pc8_b), .out_pay(out_pay_b), .out_exc(out_exc_b),
      .occ(occ_b)
   );

   task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a FIFO of at most two entries; flush/reset empty it, PC policy tracked separately.
   always @(posedge clk) begin
      int   n;
      bit   do_push, do_pop;
      ent_t e;
      n       = q.size();
      do_push = in_valid && (n < 2);
      do_pop  = (n > 0) && out_ready;
      e       = '{ir: in_ir, pc: in_pc8, pay: in_pay, exc: in_exc};
      if (reset) begin
         q.delete();
         pc_a = '0; pc_a_known = 1'b1;
         pc_b = '0; pc_b_known = 1'b1;
      end else if (clr || int_clr) begin
         if (n > 0) begin
            pc_a = q[0].pc; pc_a_known = 1'b1;
         end
         q.delete();
         pc_b = '0; pc_b_known = 1'b1;
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(e);
         if (q.size() > 0) begin
            pc_a = q[0].pc; pc_a_known = 1'b1;
            pc_b = q[0].pc; pc_b_known = 1'b1;
         end else if (do_pop) begin
            pc_a_known = 1'b0;
            pc_b_known = 1'b0;
         end
      end
   end

   task automatic checkOutput();
      int   n;
      ent_t h;
      n = q.size();
      h = (n > 0) ? q[0] : '0;
      cmp("a_valid", out_valid_a, n > 0);
      cmp("a_occ",   occ_a, n);
      cmp("a_ready", in_ready_a, n < 2);
      cmp("a_ir",    out_ir_a, h.ir);
      cmp("a_pay",   out_pay_a, h.pay);
      cmp("a_exc",   out_exc_a, h.exc);
      if (n > 0) cmp("a_pc8", out_pc8_a, h.pc);
      else if (pc_a_known) cmp("a_pc8_hold", out_pc8_a, pc_a);
      cmp("b_valid", out_valid_b, n > 0);
      cmp("b_occ",   occ_b, n);
      cmp("b_ready", in_ready_b, n < 2);
      cmp("b_ir",    out_ir_b, h.ir[15:0]);
      cmp("b_pay",   out_pay_b, h.pay[7:0]);
      cmp("b_exc",   out_exc_b, h.exc[2:0]);
      if (n > 0) cmp("b_pc8", out_pc8_b, h.pc);
      else if (pc_b_known) cmp("b_pc8_hold", out_pc8_b, pc_b);
   endtask

   always @(negedge clk) if (chk_en) checkOutput();

   task automatic applyStimulus(input bit rst, input bit cl, input bit ic, input bit v,
                                input bit rdy, input logic [31:0] ir, input logic [31:0] pc);
      reset     = rst;
      clr       = cl;
      int_clr   = ic;
      in_valid  = v;
      out_ready = rdy;
      in_ir     = ir;
      in_pc8    = pc;
      in_pay    = {ir, pc, ~ir};
      in_exc    = ir[4:0] ^ pc[4:0] ^ 5'h15;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0, 0, '0, '0);
      chk_en = 1'b1;
      cmp("rst_occ",   occ_a, 2'd0);
      cmp("rst_valid", out_valid_a, 1'b0);
      cmp("rst_ready", in_ready_a, 1'b1);
      cmp("rst_pc8",   out_pc8_a, 32'h0);

      // Single entry in and out.
      applyStimulus(0, 0, 0, 1, 1, 32'h8C220004, 32'h3008);
      cmp("r031_valid", out_valid_a, 1'b1);
      cmp("r031_ir",    out_ir_a, 32'h8C220004);
      cmp("r031_occ",   occ_a, 2'd1);
      cmp("r031_b_ir",  out_ir_b, 16'h0004);
      applyStimulus(0, 0, 0, 0, 1, '0, '0);
      cmp("r031_occ0",  occ_a, 2'd0);
      cmp("r031_ir0",   out_ir_a, 32'h0);

      // Skid fill and ordered drain.
      applyStimulus(0, 0, 0, 1, 0, 32'h11, 32'h3000);
      applyStimulus(0, 0, 0, 1, 0, 32'h22, 32'h3004);
      cmp("r032_occ2",  occ_a, 2'd2);
      cmp("r032_ready", in_ready_a, 1'b0);
      cmp("r032_ir11",  out_ir_a, 32'h11);
      applyStimulus(0, 0, 0, 0, 1, '0, '0);
      cmp("r032_ir22",  out_ir_a, 32'h22);
      cmp("r032_pc22",  out_pc8_a, 32'h3004);
      applyStimulus(0, 0, 0, 0, 1, '0, '0);
      cmp("r032_empty", out_valid_a, 1'b0);

      // Interrupt flush with a simultaneous push.
      applyStimulus(0, 0, 0, 1, 0, 32'h44, 32'h3010);
      applyStimulus(0, 0, 1, 1, 0, 32'h33, 32'h4000);
      cmp("r033_occ",   occ_a, 2'd0);
      cmp("r033_ir",    out_ir_a, 32'h0);
      cmp("r033_exc",   out_exc_a, 5'h0);
      cmp("r033_pc_a",  out_pc8_a, 32'h3010);
      cmp("r033_pc_b",  out_pc8_b, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, '0, '0);
      cmp("r033_hold",  out_pc8_a, 32'h3010);

      // Reset together with clr while full.
      applyStimulus(0, 0, 0, 1, 0, 32'h55, 32'h3020);
      applyStimulus(0, 0, 0, 1, 0, 32'h66, 32'h3024);
      cmp("r034_occ2",  occ_a, 2'd2);
      applyStimulus(1, 1, 0, 1, 1, 32'h77, 32'h3028);
      cmp("r034_occ",   occ_a, 2'd0);
      cmp("r034_pc",    out_pc8_a, 32'h0);
      cmp("r034_pay",   out_pay_a, 96'h0);
      cmp("r034_ready", in_ready_a, 1'b1);

      // Back-to-back streaming at full rate.
      for (int i = 1; i <= 100; i++) begin
         applyStimulus(0, 0, 0, 1, 1, i, 32'h5000 + 4 * i);
         cmp("r035_occ", occ_a, 2'd1);
         cmp("r035_ir",  out_ir_a, i);
      end
      applyStimulus(0, 0, 0, 0, 1, '0, '0);

      for (int k = 0; k < 3000; k++) begin
         int r;
         r = $urandom_range(0, 63);
         applyStimulus(r == 0, r inside {[1:3]}, r inside {[4:5]},
                       ($urandom % 4) != 0, ($urandom % 3) != 0, $urandom, $urandom);
      end

      applyStimulus(0, 0, 0, 0, 1, '0, '0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 The block SHALL have parameter IR_W, default 32, instruction field width.
REQ-002 The block SHALL have parameter PC_W, default 32, PC+8 field width.
REQ-003 The block SHALL have parameter PAY_W, default 96, payload width (ALU result, RT, extended-ALU result concatenated).
REQ-004 The block SHALL have parameter EXC_W, default 5, exception code width.
REQ-005 The block SHALL have parameter KEEP_PC, default 1, meaning 1 = PC field is retained on flush, 0 = cleared.
REQ-006 clk  input  1  single clock, all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high; clears all state.
REQ-008 clr  input  1  pipeline flush (hazard bubble), synchronous.
REQ-009 int_clr  input  1  interrupt/exception flush, synchronous; same effect as clr.
REQ-010 in_valid  input  1  upstream entry present.
REQ-011 in_ready  output  1  block accepts an entry this cycle.
REQ-012 in_ir / in_pc8 / in_pay / in_exc  input  IR_W / PC_W / PAY_W / EXC_W  upstream fields.
REQ-013 out_valid  output  1  head entry present.
REQ-014 out_ready  input  1  downstream consumes head this cycle.
REQ-015 out_ir / out_pc8 / out_pay / out_exc  output  IR_W / PC_W / PAY_W / EXC_W  head entry fields, driven directly from registers.
REQ-016 occ  output  2  number of stored entries (0..2).

Function
REQ-017 Storage SHALL be two entries: head (drives outputs) and skid (overflow); skid is only occupied while head is occupied.
REQ-018 in_ready SHALL equal NOT skid-occupied, from registered state only (no combinational path from out_ready).
REQ-019 Push SHALL occur when in_valid AND in_ready; pop SHALL occur when out_valid AND out_ready.
REQ-020 Occupancy transitions (EMPTY, ONE, FULL): EMPTY+push -> ONE; ONE+push only -> FULL; ONE+pop only -> EMPTY; ONE+push+pop -> ONE; FULL+pop -> ONE (skid moves to head); FULL never pushes.
REQ-021 Latency SHALL be one cycle: entry pushed at edge N is visible on out_* after edge N when the head is empty or popped at edge N.
REQ-022 Entry order SHALL be preserved: skid entry always leaves after head entry.
REQ-023 When out_valid=0, out_ir, out_pay, out_exc SHALL read 0.
REQ-024 clr OR int_clr SHALL, at the next edge, empty both entries (occ=0), zero IR, payload, exc fields, and discard any simultaneous push and pop.
REQ-025 On flush with KEEP_PC=1, out_pc8 SHALL retain its pre-flush value until the next push; with KEEP_PC=0 it SHALL become 0.
REQ-026 Priority SHALL be reset > (clr|int_clr) > push/pop.
REQ-027 occ SHALL equal head-occupied + skid-occupied at all times; occ=3 is unreachable.

Reset
REQ-028 On reset, at the next edge, all fields, out_pc8 included, SHALL be 0, out_valid=0, occ=0, in_ready=1, regardless of KEEP_PC.
REQ-029 Reset asserted mid-operation (occ=2) SHALL discard both entries identically.
REQ-030 Initial (pre-reset) register values SHALL be 0.

Verification
REQ-031 Push ir=0x8C220004, pc8=0x3008, out_ready=1 for one cycle -> out_valid=1, out_ir=0x8C220004 next cycle, occ=1, then occ=0.
REQ-032 out_ready=0, push A=0x11 then B=0x22 -> occ=2, in_ready=0, out_ir=0x11; raise out_ready -> out_ir=0x11 then 0x22, then out_valid=0.
REQ-033 occ=1 head pc8=0x3010, assert int_clr together with in_valid (ir=0x33) -> occ=0, out_ir=0, out_exc=0, out_pc8=0x3010 (KEEP_PC=1) or 0 (KEEP_PC=0).
REQ-034 occ=2, assert reset and clr together -> occ=0, all outputs 0, in_ready=1.
REQ-035 Continuous in_valid=1, out_ready=1, ir incrementing 1..100 -> outputs 1..100 in order, one per cycle, occ stays 1.
REQ-036 Parameter sweep IR_W=16, PAY_W=8, EXC_W=3 -> REQ-031..REQ-034 pass unchanged.
